snake_move_ctrl: RTL and testbench

Game-step controller for the snake datapath. It generates the movement tick, holds the current direction, computes the next head coordinate and detects wall, self and food hits. It drives the 4-segment body shift register with a one-cycle shift strobe, the new head coordinate and the current length code. It sits between the button/direction decoder and food generator on the input side and the body register on the output side.

---
 rtl/snake_pkg.sv | 18 +
 rtl/snake_tick_gen.sv | 18 +
 rtl/snake_move_ctrl.sv | 95 +++++++++
 tb/tb_snake_move_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared encodings, FSM states and segment pack/unpack helpers for the snake datapath
package snake_pkg;
  localparam int COORD_W = 4;
  localparam int MAX_LEN = 3;
  localparam logic [1:0] DIR_UP = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;
  localparam logic [1:0] DIR_LEFT = 2'd3;
  typedef enum logic [1:0] {IDLE, RUN, MOVE, OVER} state_t;
  function automatic logic [COORD_W-1:0] seg_get(input logic [4*COORD_W-1:0] v, input int i);
    return v[i*COORD_W +: COORD_W];
  endfunction
  function automatic logic [4*COORD_W-1:0] seg_set(input logic [4*COORD_W-1:0] v, input int i,
                                                   input logic [COORD_W-1:0] c);
    seg_set = v;
    seg_set[i*COORD_W +: COORD_W] = c;
  endfunction
endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: terminal-count divider emitting one tick every TICK_DIV running cycles
module snake_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = run && cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear || tick) cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
endmodule

// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl: game-step FSM computing head moves, growth, scoring and collisions
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter bit WRAP = 1'b1,
  parameter logic [3:0] START_X = 4'd4,
  parameter logic [3:0] START_Y = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  dir_in,
  input  logic        dir_vld,
  input  logic [3:0]  food_x,
  input  logic [3:0]  food_y,
  input  logic        food_valid,
  input  logic [15:0] body_x,
  input  logic [15:0] body_y,
  output logic [3:0]  head_x,
  output logic [3:0]  head_y,
  output logic        step,
  output logic        body_clr,
  output logic [3:0]  len,
  output logic        ate,
  output logic [7:0]  score,
  output logic        game_over
);
  state_t state, state_n;
  logic [1:0] cur_dir, pend_dir;
  logic tick, restart, move, grow, wall_hit, self_hit, hit;
  logic [3:0] cx, cy, nx, ny;
  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk), .rst(rst), .clear(restart), .run(state == RUN), .tick(tick)
  );
  assign restart = start && (state == IDLE || state == OVER);
  assign move = state == MOVE;
  assign game_over = state == OVER;
  assign cx = seg_get(body_x, 0);
  assign cy = seg_get(body_y, 0);
  assign nx = pend_dir == DIR_RIGHT ? cx + 4'd1 : pend_dir == DIR_LEFT ? cx - 4'd1 : cx;
  assign ny = pend_dir == DIR_DOWN ? cy + 4'd1 : pend_dir == DIR_UP ? cy - 4'd1 : cy;
  assign wall_hit = !WRAP && ((pend_dir == DIR_RIGHT && cx == 4'd15) || (pend_dir == DIR_LEFT && cx == 4'd0) ||
                              (pend_dir == DIR_DOWN && cy == 4'd15) || (pend_dir == DIR_UP && cy == 4'd0));
  assign grow = food_valid && nx == food_x && ny == food_y;
  assign hit = wall_hit || self_hit;
  // the tail cell is vacated by this move unless the snake grows into it
  always_comb begin
    self_hit = 1'b0;
    for (int i = 1; i <= MAX_LEN; i++)
      if (seg_get(body_x, i) == nx && seg_get(body_y, i) == ny && (i < int'(len) || (grow && i == int'(len))))
        self_hit = 1'b1;
  end
  always_comb
    state_n = (state == IDLE || state == OVER) ? (start ? RUN : state) :
              state == RUN ? (tick ? MOVE : RUN) : (hit ? OVER : RUN);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      step <= 1'b0;
      ate <= 1'b0;
      body_clr <= 1'b0;
      len <= '0;
      score <= '0;
      head_x <= START_X;
      head_y <= START_Y;
      cur_dir <= DIR_RIGHT;
      pend_dir <= DIR_RIGHT;
    end else begin
      step <= move && !hit;
      ate <= move && !hit && grow;
      body_clr <= restart;
      if (restart) begin
        len <= '0;
        score <= '0;
        head_x <= START_X;
        head_y <= START_Y;
        cur_dir <= DIR_RIGHT;
        pend_dir <= DIR_RIGHT;
      end else begin
        if (dir_vld && (state == RUN || move) && dir_in != (cur_dir ^ 2'd2)) pend_dir <= dir_in;
        if (move) cur_dir <= pend_dir;
        if (move && !hit) begin
          head_x <= nx;
          head_y <= ny;
          if (grow) begin
            len <= len < 4'(MAX_LEN) ? len + 4'd1 : len;
            score <= score == 8'hff ? score : score + 8'd1;
          end
        end
      end
    end
endmodule

// File: tb/tb_snake_move_ctrl.sv
// tb_snake_move_ctrl: wrapping and walled controllers driven in lockstep against a snake model
module tb_snake_move_ctrl;
  localparam int TD = 4;
  logic clk = 0, rst = 0, start = 0, dir_vld = 0, food_valid = 0;
  logic [1:0] dir_in = 0;
  logic [3:0] food_x = 0, food_y = 0;
  logic [1:0] stp, clr, at, go;
  logic [1:0][3:0] hx, hy, ln;
  logic [1:0][7:0] sc;
  logic [1:0][15:0] bx, by;
  int errors = 0, checks = 0;
  bit mrun[2], estep[2], eate[2], eover[2];
  int mlen[2], msc[2];
  logic [1:0] mdir[2], mpend[2];
  logic [3:0] ehx[2], ehy[2];
  logic [7:0] mseg[2][4];

  snake_move_ctrl #(.TICK_DIV(TD), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .dir_vld(dir_vld), .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .body_x(bx[0]), .body_y(by[0]), .head_x(hx[0]), .head_y(hy[0]), .step(stp[0]),
    .body_clr(clr[0]), .len(ln[0]), .ate(at[0]), .score(sc[0]), .game_over(go[0]));
  snake_move_ctrl #(.TICK_DIV(TD), .WRAP(1'b0)) dut_n (
    .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .dir_vld(dir_vld), .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .body_x(bx[1]), .body_y(by[1]), .head_x(hx[1]), .head_y(hy[1]), .step(stp[1]),
    .body_clr(clr[1]), .len(ln[1]), .ate(at[1]), .score(sc[1]), .game_over(go[1]));

  always #5 clk = ~clk;

  // body shift registers the controllers feed and read back
  always @(posedge clk or posedge rst)
    for (int d = 0; d < 2; d++)
      if (rst || clr[d]) begin
        bx[d] <= {4{4'd4}};
        by[d] <= {4{4'd8}};
      end else if (stp[d]) begin
        bx[d] <= {bx[d][11:0], hx[d]};
        by[d] <= {by[d][11:0], hy[d]};
      end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string t);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.%0d.step", t, d), 32'(stp[d]), 32'(estep[d]));
      chk($sformatf("%s.%0d.ate", t, d), 32'(at[d]), 32'(eate[d]));
      chk($sformatf("%s.%0d.head_x", t, d), 32'(hx[d]), 32'(ehx[d]));
      chk($sformatf("%s.%0d.head_y", t, d), 32'(hy[d]), 32'(ehy[d]));
      chk($sformatf("%s.%0d.len", t, d), 32'(ln[d]), 32'(mlen[d]));
      chk($sformatf("%s.%0d.score", t, d), 32'(sc[d]), 32'(msc[d]));
      chk($sformatf("%s.%0d.game_over", t, d), 32'(go[d]), 32'(eover[d]));
    end
  endtask

  task automatic m_init(input int d, input bit run);
    mrun[d] = run; eover[d] = 0; estep[d] = 0; eate[d] = 0;
    mlen[d] = 0; msc[d] = 0; mdir[d] = 1; mpend[d] = 1; ehx[d] = 4; ehy[d] = 8;
    for (int k = 0; k < 4; k++) mseg[d][k] = 8'h48;
  endtask

  task automatic m_dir(input logic [1:0] v);
    for (int d = 0; d < 2; d++)
      if (mrun[d] && v != (mdir[d] ^ 2'd2)) mpend[d] = v;
  endtask

  // the cells still occupied after this move are the head..tail minus the tail, or all of them when growing
  task automatic m_move();
    for (int d = 0; d < 2; d++) begin
      int x, y, nx, ny, keep;
      bit wall, grow, hit;
      estep[d] = 0; eate[d] = 0;
      if (!mrun[d]) continue;
      mdir[d] = mpend[d];
      x = int'(mseg[d][0][7:4]); y = int'(mseg[d][0][3:0]);
      nx = x + (mdir[d] == 1 ? 1 : mdir[d] == 3 ? -1 : 0);
      ny = y + (mdir[d] == 2 ? 1 : mdir[d] == 0 ? -1 : 0);
      wall = nx < 0 || nx > 15 || ny < 0 || ny > 15;
      nx = (nx + 16) % 16; ny = (ny + 16) % 16;
      grow = food_valid && nx == int'(food_x) && ny == int'(food_y);
      keep = grow ? mlen[d] + 1 : mlen[d];
      hit = 0;
      for (int k = 0; k < keep; k++) if (mseg[d][k] == 8'(nx * 16 + ny)) hit = 1;
      if ((wall && d == 1) || hit) begin
        mrun[d] = 0; eover[d] = 1;
      end else begin
        for (int k = 3; k > 0; k--) mseg[d][k] = mseg[d][k-1];
        mseg[d][0] = 8'(nx * 16 + ny);
        estep[d] = 1; ehx[d] = 4'(nx); ehy[d] = 4'(ny);
        if (grow) begin
          eate[d] = 1;
          mlen[d] = mlen[d] < 3 ? mlen[d] + 1 : 3;
          msc[d] = msc[d] < 255 ? msc[d] + 1 : 255;
        end
      end
    end
  endtask

  task automatic do_reset(input string t);
    rst = 1;
    #1;
    for (int d = 0; d < 2; d++) m_init(d, 0);
    chk_all(t);
    for (int d = 0; d < 2; d++) chk($sformatf("%s.%0d.body_clr", t, d), 32'(clr[d]), 0);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic do_start(input string t);
    bit ec[2];
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int d = 0; d < 2; d++) begin
      ec[d] = !mrun[d];
      if (ec[d]) m_init(d, 1);
    end
    chk_all(t);
    for (int d = 0; d < 2; d++) chk($sformatf("%s.%0d.body_clr", t, d), 32'(clr[d]), 32'(ec[d]));
  endtask

  // one step period: TD cycles with no step, then the step cycle; direction requests land in RUN cycles
  task automatic run_period(input string t, input int nd, input logic [1:0] a, input logic [1:0] b, input bit st);
    for (int c = 0; c < TD; c++) begin
      @(negedge clk);
      dir_vld = 0;
      start = st && c == 2;
      if (c < nd) begin
        dir_in = c == 0 ? a : b;
        dir_vld = 1;
        m_dir(dir_in);
      end
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("%s.%0d.idle_step", t, d), 32'(stp[d]), 0);
        chk($sformatf("%s.%0d.idle_clr", t, d), 32'(clr[d]), 0);
        chk($sformatf("%s.%0d.idle_ate", t, d), 32'(at[d]), 0);
      end
    end
    @(negedge clk);
    dir_vld = 0;
    start = 0;
    m_move();
    chk_all(t);
  endtask

  task automatic set_food(input bit v, input logic [3:0] x, input logic [3:0] y);
    food_valid = v; food_x = x; food_y = y;
  endtask

  initial begin
    #2;
    do_reset("reset");
    repeat (3) @(negedge clk);
    chk_all("idle");
    do_start("start");
    for (int i = 0; i < 12; i++) run_period($sformatf("east%0d", i), i == 3 ? 1 : 0, 2'd3, 2'd0, 0);
    do_reset("midreset");
    do_start("start2");
    set_food(1, 4, 9); run_period("down_eat", 1, 2'd2, 2'd0, 0);
    set_food(1, 5, 9); run_period("last_wins", 2, 2'd3, 2'd1, 0);
    set_food(1, 5, 8); run_period("up_eat", 1, 2'd0, 2'd0, 0);
    set_food(0, 0, 0); run_period("tail_free", 1, 2'd3, 2'd0, 0);
    set_food(1, 3, 8); run_period("len_sat", 0, 2'd0, 2'd0, 0);
    set_food(0, 0, 0); run_period("turn_down", 1, 2'd2, 2'd0, 0);
    run_period("turn_right", 1, 2'd1, 2'd0, 0);
    set_food(1, 4, 8); run_period("tail_grow_hit", 1, 2'd0, 2'd0, 0);
    repeat (2) @(negedge clk);
    chk_all("over_frozen");
    do_start("restart");
    for (int i = 0; i < 60; i++) begin
      set_food(1'($urandom_range(0, 1)), mseg[0][0][7:4] + 4'($urandom_range(0, 2)) - 4'd1,
               mseg[0][0][3:0] + 4'($urandom_range(0, 2)) - 4'd1);
      run_period($sformatf("rnd%0d", i), $urandom_range(0, 2), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
      if (!mrun[0] || !mrun[1]) begin
        do_reset($sformatf("rnd_rst%0d", i));
        do_start($sformatf("rnd_start%0d", i));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
